// File: rtl/hazard_control_if.sv
// hazard_control_if: pipeline-side bus between the datapath and the hazard/flow-control unit.
interface hazard_control_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int CNT_WIDTH = 16
);
  logic [ADDRESS_WIDTH-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM;
  logic FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic MemTimeout;
  logic [CNT_WIDTH-1:0] StallCount, FlushCount;
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout, StallCount, FlushCount
  );
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_control.sv
// hazard_control: RV32I forwarding, load-use/branch hazards and a memory-wait FSM with watchdog.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_control #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int WAIT_LIMIT = 64,
  parameter int CNT_WIDTH = 16
) (
  input logic CLK,
  input logic RST,
  hazard_control_if.slave hz
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  state_t state;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic lw_stall, entry, mem_stall, stall_f, flush_e, mem_timeout;
  function automatic logic [1:0] fwd(input logic [ADDRESS_WIDTH-1:0] rs, rd_m, rd_w,
                                     input logic we_m, we_w);
    return (we_m && rd_m != '0 && rd_m == rs) ? 2'b10 :
           (we_w && rd_w != '0 && rd_w == rs) ? 2'b01 : 2'b00;
  endfunction
  // The entry cycle already freezes the pipe; the exit cycle (ready) falls back to RUN rules.
  assign lw_stall = hz.ResultSrcE == 2'b01 && hz.RdE != '0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
  assign entry = state == RUN && hz.MemReqM && !hz.MemReadyM;
  assign mem_stall = entry || (state == MEM_WAIT && !hz.MemReadyM);
  assign stall_f = !RST && (mem_stall || (lw_stall && !hz.PCSrcE));
  assign flush_e = RST || (!mem_stall && (lw_stall || hz.PCSrcE));
  assign hz.StallF = stall_f;
  assign hz.StallD = stall_f;
  assign hz.StallE = !RST && mem_stall;
  assign hz.StallM = !RST && mem_stall;
  assign hz.FlushD = RST || (!mem_stall && hz.PCSrcE);
  assign hz.FlushE = flush_e;
  assign hz.FlushW = RST || mem_stall;
  assign hz.ForwardAE = RST ? 2'b00 : fwd(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
  assign hz.ForwardBE = RST ? 2'b00 : fwd(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
  assign hz.MemTimeout = mem_timeout;
  // wait_cnt counts every frozen cycle of the current wait, the entry cycle included.
  assign wait_nxt = entry ? WW'(1) :
                    (state == MEM_WAIT && !hz.MemReadyM && wait_cnt != WW'(WAIT_LIMIT)) ? wait_cnt + WW'(1) :
                    wait_cnt;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
      wait_cnt <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= mem_stall ? MEM_WAIT : RUN;
      wait_cnt <= wait_nxt;
      mem_timeout <= mem_timeout || wait_nxt == WW'(WAIT_LIMIT);
    end
  end
`ifdef HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0] stall_count, flush_count;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_f && !(&stall_count)) stall_count <= stall_count + 1'b1;
      if (flush_e && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
  end
  assign hz.StallCount = stall_count;
  assign hz.FlushCount = flush_count;
`else
  assign hz.StallCount = CNT_WIDTH'(0);
  assign hz.FlushCount = CNT_WIDTH'(0);
`endif
endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed test-plan steps plus randomized traffic against a behavioural model.
module tb_hazard_control;
  localparam int AW = 5, CW = 16, LIM = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic CLK = 0, RST = 1;
  always #5 CLK = ~CLK;
  hazard_control_if #(.ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) hz();
  hazard_control #(.ADDRESS_WIDTH(AW), .WAIT_LIMIT(LIM), .CNT_WIDTH(CW)) dut (.CLK(CLK), .RST(RST), .hz(hz));
  int passed = 0, total = 0;
  bit mw, tmo;
  int streak, sc, fc;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1;
`else
  localparam bit PERF = 0;
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
    if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2'b10;
    if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction
  task automatic set(input int rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw, rsrc,
                     input bit wm, ww, pc, req, rdy);
    hz.Rs1D = AW'(rs1d); hz.Rs2D = AW'(rs2d); hz.Rs1E = AW'(rs1e); hz.Rs2E = AW'(rs2e);
    hz.RdE = AW'(rde); hz.RdM = AW'(rdm); hz.RdW = AW'(rdw); hz.ResultSrcE = 2'(rsrc);
    hz.RegWriteM = wm; hz.RegWriteW = ww; hz.PCSrcE = pc; hz.MemReqM = req; hz.MemReadyM = rdy;
  endtask
  // Model: the pipe is frozen by memory if ready is low and either a request starts or the previous cycle was frozen.
  task automatic cycle();
    bit lw, ms, sf, fe;
    @(negedge CLK);
    if (RST) begin mw = 0; tmo = 0; streak = 0; sc = 0; fc = 0; end
    lw = hz.ResultSrcE == 2'b01 && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    ms = !RST && !hz.MemReadyM && (mw || hz.MemReqM);
    sf = !RST && (ms || (lw && !hz.PCSrcE));
    fe = RST || (!ms && (lw || hz.PCSrcE));
    chk("StallF", hz.StallF, sf);
    chk("StallD", hz.StallD, sf);
    chk("StallE", hz.StallE, ms);
    chk("StallM", hz.StallM, ms);
    chk("FlushD", hz.FlushD, RST || (!ms && hz.PCSrcE));
    chk("FlushE", hz.FlushE, fe);
    chk("FlushW", hz.FlushW, RST || ms);
    chk("ForwardAE", hz.ForwardAE, RST ? 2'b00 : fwd_ref(hz.Rs1E));
    chk("ForwardBE", hz.ForwardBE, RST ? 2'b00 : fwd_ref(hz.Rs2E));
    chk("MemTimeout", hz.MemTimeout, tmo);
    chk("StallCount", hz.StallCount, PERF ? sc : 0);
    chk("FlushCount", hz.FlushCount, PERF ? fc : 0);
    @(posedge CLK);
    if (!RST) begin
      mw = ms;
      streak = ms ? streak + 1 : 0;
      if (streak >= LIM) tmo = 1;
      if (sf && sc < CMAX) sc++;
      if (fe && fc < CMAX) fc++;
    end
    #1;
  endtask
  initial begin
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    cycle();
    RST = 0;
    // forwarding priority
    set(0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 0, 1);
    #1 chk("fwd_mem_prio", hz.ForwardAE, 2'b10);
    cycle();
    set(0, 0, 5, 5, 0, 0, 5, 0, 1, 1, 0, 0, 1);
    #1 chk("fwd_wb", hz.ForwardAE, 2'b01);
    chk("fwd_wb_b", hz.ForwardBE, 2'b01);
    cycle();
    // load-use, then released
    set(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 1);
    #1 chk("lu_stallf", hz.StallF, 1'b1);
    chk("lu_flushe", hz.FlushE, 1'b1);
    cycle();
    set(0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("lu_release", {hz.StallF, hz.StallD, hz.FlushE}, 3'b000);
    cycle();
    // branch overrides load-use
    set(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 1, 0, 1);
    #1 chk("br_lu", {hz.StallF, hz.FlushD, hz.FlushE}, 3'b011);
    cycle();
    // memory wait for 3 cycles
    for (int i = 0; i < 3; i++) begin
      set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1 chk("mw_stalls", {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW}, 5'b11111);
      cycle();
    end
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1 chk("mw_exit", {hz.StallM, hz.FlushW}, 2'b00);
    cycle();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("mw_back_run", hz.StallE, 1'b0);
    cycle();
    // branch pending during wait
    for (int i = 0; i < 2; i++) begin
      set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      #1 chk("br_wait", {hz.FlushD, hz.FlushE}, 2'b00);
      cycle();
    end
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    #1 chk("br_exit", {hz.FlushD, hz.FlushE}, 2'b11);
    cycle();
    // watchdog from a clean reset
    RST = 1;
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    RST = 0;
    for (int i = 0; i < 6; i++) begin
      set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1 chk("wd_rise", hz.MemTimeout, i >= LIM);
      cycle();
    end
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    #1 chk("wd_sticky", hz.MemTimeout, 1'b1);
    chk("perf_stall6", hz.StallCount, PERF ? 6 : 0);
    // async reset in the middle of a wait
    for (int i = 0; i < 2; i++) begin
      set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cycle();
    end
    RST = 1;
    #1 chk("arst_tmo", hz.MemTimeout, 1'b0);
    chk("arst_outs", {hz.StallF, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushW}, 5'b00111);
    chk("arst_cnt", hz.StallCount, 0);
    cycle();
    RST = 0;
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("arst_run", hz.StallM, 1'b0);
    cycle();
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      RST = $urandom_range(0, 59) == 0;
      set($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 7);
      cycle();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
